// File: rtl/vga_capture.sv
// Sink end of a VGA timing stream: recovers position from the sync edges, checks line and
// frame lengths, and writes active pixels to a frame-buffer port once the timing is locked.
module vga_capture #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BACK   = 48,
  parameter int V_BACK   = 33,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_en,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic [3:0]        red_in,
  input  logic [3:0]        green_in,
  input  logic [3:0]        blue_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              locked,
  output logic              line_err,
  output logic [1:0]        state_dbg
);

  // Handshake: pix_en is a valid-only strobe with no backpressure; inputs are sampled only
  // when it is high, and wr_en/frame_done/line_err are one-cycle strobes in the following cycle.
  localparam logic [1:0] ST_SEEK   = 2'd0;
  localparam logic [1:0] ST_SYNC   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [10:0] H_MAX    = 11'd2047;
  localparam logic [10:0] H_LO     = 11'(H_BACK);
  localparam logic [10:0] H_HI     = 11'(H_BACK + H_ACTIVE);
  localparam logic [9:0]  V_MAX    = 10'd1023;
  localparam logic [9:0]  V_LO     = 10'(V_BACK);
  localparam logic [9:0]  V_HI     = 10'(V_BACK + V_ACTIVE);
  localparam logic [11:0] LINE_MAX = 12'hfff;
  localparam logic [11:0] H_TOT    = 12'(H_TOTAL);
  localparam logic [10:0] FRM_MAX  = 11'h7ff;
  localparam logic [10:0] V_TOT    = 11'(V_TOTAL);

  logic [1:0]        state_q, state_d;
  logic [10:0]       hpos_q, hpos_d;
  logic [9:0]        vline_q, vline_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              hs_prev_q, hs_prev_d;
  logic              vs_prev_q, vs_prev_d;
  logic [11:0]       line_cnt_q, line_cnt_d;
  logic [10:0]       frame_lines_q, frame_lines_d;
  logic              h_seen_q, h_seen_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]       wr_data_q, wr_data_d;
  logic              frame_done_q, frame_done_d;
  logic              line_err_q, line_err_d;

  logic              h_edge, v_edge, active, line_bad, frame_bad;
  logic [10:0]       cur_h, frame_meas;
  logic [9:0]        cur_v;
  logic [11:0]       line_meas;
  logic [ADDR_W-1:0] addr_base;

  always_comb begin
    h_edge     = pix_en && !hs_prev_q && hsync_in;
    v_edge     = pix_en && !vs_prev_q && vsync_in;
    cur_h      = h_edge ? 11'd0 : ((hpos_q == H_MAX) ? H_MAX : hpos_q + 11'd1);
    if (v_edge)      cur_v = 10'd0;
    else if (h_edge) cur_v = (vline_q == V_MAX) ? V_MAX : vline_q + 10'd1;
    else             cur_v = vline_q;
    active     = (cur_h >= H_LO) && (cur_h < H_HI) && (cur_v >= V_LO) && (cur_v < V_HI);
    // The edge strobe itself closes the line, hence the +1 on the running count.
    line_meas  = (line_cnt_q == LINE_MAX) ? LINE_MAX : line_cnt_q + 12'd1;
    frame_meas = (h_edge && frame_lines_q != FRM_MAX) ? frame_lines_q + 11'd1 : frame_lines_q;
    line_bad   = h_edge && h_seen_q && (line_meas != H_TOT);
    frame_bad  = v_edge && (frame_meas != V_TOT);
    addr_base  = v_edge ? '0 : addr_q;

    state_d       = state_q;
    hpos_d        = hpos_q;
    vline_d       = vline_q;
    addr_d        = addr_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    line_cnt_d    = line_cnt_q;
    frame_lines_d = frame_lines_q;
    h_seen_d      = h_seen_q;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    line_err_d    = 1'b0;

    if (pix_en) begin
      hs_prev_d     = hsync_in;
      vs_prev_d     = vsync_in;
      hpos_d        = cur_h;
      vline_d       = cur_v;
      line_cnt_d    = h_edge ? 12'd0 : line_meas;
      frame_lines_d = v_edge ? 11'd0 : frame_meas;
      addr_d        = addr_base;
      if (h_edge) h_seen_d = 1'b1;
      case (state_q)
        ST_SEEK: begin
          if (v_edge) begin
            // The partial line in progress at lock-on is never measured.
            state_d    = ST_SYNC;
            h_seen_d   = 1'b0;
            line_cnt_d = 12'd0;
          end
        end
        ST_SYNC: begin
          if (line_bad)    state_d = ST_SEEK;
          else if (v_edge) state_d = frame_bad ? ST_SEEK : ST_LOCKED;
        end
        ST_LOCKED: begin
          if (line_bad || frame_bad) begin
            state_d    = ST_SEEK;
            line_err_d = 1'b1;
          end else begin
            if (v_edge) frame_done_d = 1'b1;
            if (active) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_base;
              wr_data_d = {red_in, green_in, blue_in};
              addr_d    = addr_base + 1'b1;
            end
          end
        end
        default: state_d = ST_SEEK;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_SEEK;
      hpos_q        <= '0;
      vline_q       <= '0;
      addr_q        <= '0;
      hs_prev_q     <= 1'b1;
      vs_prev_q     <= 1'b1;
      line_cnt_q    <= '0;
      frame_lines_q <= '0;
      h_seen_q      <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      frame_done_q  <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      hpos_q        <= hpos_d;
      vline_q       <= vline_d;
      addr_q        <= addr_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      line_cnt_q    <= line_cnt_d;
      frame_lines_q <= frame_lines_d;
      h_seen_q      <= h_seen_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      frame_done_q  <= frame_done_d;
      line_err_q    <= line_err_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign line_err   = line_err_q;
  assign locked     = (state_q == ST_LOCKED);
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a scaled-down raster (16x12 total, 8x6 active) so whole frames
// fit in a short run; expected writes are queued as pixels are driven and popped on wr_en.
module tb_vga_capture;
  localparam int HA = 8, VA = 6, HB = 3, VB = 2, HT = 16, VT = 12, AW = 19;
  localparam int HS_W = 3;
  localparam int NFR  = HA * VA;

  logic          clk = 1'b0;
  logic          rst, pix_en, hsync_in, vsync_in;
  logic [3:0]    red_in, green_in, blue_in;
  logic          wr_en, frame_done, locked, line_err;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [1:0]    state_dbg;

  int n_vec = 0, n_err = 0;
  logic [AW+11:0] exp_q[$];
  int wr_cnt = 0, done_cnt = 0, err_cnt = 0;
  logic [AW-1:0] last_addr = '0;
  bit rand_gap = 1'b0;
  int exp_addr = 0;
  logic prev_pix;

  always #5 clk = ~clk;

  vga_capture #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_BACK(HB), .V_BACK(VB),
    .H_TOTAL(HT), .V_TOTAL(VT), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .locked(locked), .line_err(line_err), .state_dbg(state_dbg)
  );

  // Scoreboard / pulse monitor, sampling on the falling edge.
  initial begin
    logic [AW+11:0] e;
    prev_pix = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (wr_en) begin
          n_vec++;
          wr_cnt++;
          last_addr = wr_addr;
          if (prev_pix !== 1'b1) begin
            n_err++;
            $display("FAIL wr_strobe: wr_en=1 got, required only after a pix_en cycle");
          end
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL wr_unexpected: addr=%0d data=%h got, required no write", wr_addr, wr_data);
          end else begin
            e = exp_q.pop_front();
            if ({wr_addr, wr_data} !== e)
              begin
                n_err++;
                $display("FAIL wr_data: addr=%0d data=%h got, required addr=%0d data=%h",
                         wr_addr, wr_data, e[AW+11:12], e[11:0]);
              end
          end
        end
        if (frame_done) begin
          n_vec++;
          done_cnt++;
          if (prev_pix !== 1'b1) begin
            n_err++;
            $display("FAIL done_strobe: frame_done=1 got, required only after a pix_en cycle");
          end
        end
        if (line_err) begin
          n_vec++;
          err_cnt++;
          if (prev_pix !== 1'b1) begin
            n_err++;
            $display("FAIL err_strobe: line_err=1 got, required only after a pix_en cycle");
          end
        end
      end
      prev_pix = pix_en;
    end
  end

  // Entry and exit at posedge+2; one pix_en strobe followed by 0..6 idle clocks.
  task automatic strobe(input logic hs, input logic vs, input logic [11:0] pix);
    int gap;
    hsync_in = hs;
    vsync_in = vs;
    {red_in, green_in, blue_in} = pix;
    pix_en = 1'b1;
    @(posedge clk); #2;
    gap = rand_gap ? int'($urandom_range(0, 6)) : 3;
    if (gap > 0) begin
      pix_en = 1'b0;
      repeat (gap) begin @(posedge clk); #2; end
    end
  endtask

  task automatic send_frame(input int nlines, input int short_line, input int wr_lines,
                            input int rst_at);
    int len;
    bit wr_ok;
    logic [11:0] pix;
    wr_ok = 1'b1;
    exp_addr = 0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == short_line) ? HT - 1 : HT;
      for (int c = 0; c < len; c++) begin
        pix = 12'(l * HT + c);
        if (wr_ok && l < wr_lines && c >= HB && c < HB + HA && l >= VB && l < VB + VA) begin
          exp_q.push_back({AW'(exp_addr), pix});
          exp_addr++;
        end
        strobe((c >= len - HS_W) ? 1'b0 : 1'b1, (l >= nlines - 2) ? 1'b0 : 1'b1, pix);
        if (rst_at > 0 && wr_ok && exp_addr == rst_at) begin
          wr_ok = 1'b0;
          pix_en = 1'b0;
          repeat (2) begin @(posedge clk); #2; end
          rst = 1'b1;
          #1;
          n_vec++;
          if ({wr_en, frame_done, locked, line_err, wr_addr, wr_data} !== '0) begin
            n_err++;
            $display("FAIL rst_mid_frame: wr_en=%b done=%b locked=%b err=%b addr=%0d data=%h got, required all 0",
                     wr_en, frame_done, locked, line_err, wr_addr, wr_data);
          end
          n_vec++;
          if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL rst_drain: %0d pending writes got, required 0", exp_q.size());
          end
          #1;
          repeat (2) begin @(posedge clk); #2; end
          rst = 1'b0;
        end
      end
    end
  endtask

  task automatic check_frame(input string name, input int w0, input int d0, input int e0,
                             input int exp_w, input int exp_d, input int exp_e, input logic exp_lock);
    n_vec++;
    if (wr_cnt - w0 != exp_w) begin
      n_err++;
      $display("FAIL %s_writes: %0d got, required %0d", name, wr_cnt - w0, exp_w);
    end
    n_vec++;
    if (done_cnt - d0 != exp_d) begin
      n_err++;
      $display("FAIL %s_done: %0d got, required %0d", name, done_cnt - d0, exp_d);
    end
    n_vec++;
    if (err_cnt - e0 != exp_e) begin
      n_err++;
      $display("FAIL %s_err: %0d got, required %0d", name, err_cnt - e0, exp_e);
    end
    n_vec++;
    if (locked !== exp_lock) begin
      n_err++;
      $display("FAIL %s_locked: %b got, required %b", name, locked, exp_lock);
    end
  endtask

  task automatic run(input string name, input int nlines, input int short_line, input int wr_lines,
                     input int rst_at, input int exp_w, input int exp_d, input int exp_e,
                     input logic exp_lock);
    int w0, d0, e0;
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    send_frame(nlines, short_line, wr_lines, rst_at);
    check_frame(name, w0, d0, e0, exp_w, exp_d, exp_e, exp_lock);
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_en = 1'b0; hsync_in = 1'b1; vsync_in = 1'b1;
    {red_in, green_in, blue_in} = 12'h000;
    repeat (3) @(posedge clk);
    #2;
    n_vec++; if (wr_en !== 1'b0)      begin n_err++; $display("FAIL rst_wr_en: %b got, required 0", wr_en); end
    n_vec++; if (wr_addr !== '0)      begin n_err++; $display("FAIL rst_wr_addr: %0d got, required 0", wr_addr); end
    n_vec++; if (wr_data !== 12'h000) begin n_err++; $display("FAIL rst_wr_data: %h got, required 000", wr_data); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL rst_frame_done: %b got, required 0", frame_done); end
    n_vec++; if (locked !== 1'b0)     begin n_err++; $display("FAIL rst_locked: %b got, required 0", locked); end
    n_vec++; if (line_err !== 1'b0)   begin n_err++; $display("FAIL rst_line_err: %b got, required 0", line_err); end
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  task automatic test_lock_nominal();
    run("seek",   VT, -1, 0,  0, 0,   0, 0, 1'b0);
    run("sync",   VT, -1, 0,  0, 0,   0, 0, 1'b0);
    run("first",  VT, -1, VT, 0, NFR, 0, 0, 1'b1);
    n_vec++;
    if (last_addr !== AW'(NFR - 1)) begin
      n_err++;
      $display("FAIL last_addr: %0d got, required %0d", last_addr, NFR - 1);
    end
    run("second", VT, -1, VT, 0, NFR, 1, 0, 1'b1);
  endtask

  task automatic test_coincident();
    run("coincident", VT, -1, VT, 0, NFR, 1, 0, 1'b1);
  endtask

  task automatic test_line_err();
    run("short_line", VT, 4, 5, 0, 3 * HA, 1, 1, 1'b0);
    run("le_resync",  VT, -1, 0, 0, 0, 0, 0, 1'b0);
    run("le_relock",  VT, -1, VT, 0, NFR, 0, 0, 1'b1);
  endtask

  task automatic test_short_frame();
    run("short_frame", VT - 1, -1, VT, 0, NFR, 1, 0, 1'b1);
    run("sf_detect",   VT, -1, 0, 0, 0, 0, 1, 1'b0);
    run("sf_resync",   VT, -1, 0, 0, 0, 0, 0, 1'b0);
    run("sf_relock",   VT, -1, VT, 0, NFR, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid_frame();
    run("rst_frame",  VT, -1, VT, 20, 20, 1, 0, 1'b0);
    run("rst_resync", VT, -1, 0, 0, 0, 0, 0, 1'b0);
    run("rst_relock", VT, -1, VT, 0, NFR, 0, 0, 1'b1);
  endtask

  task automatic test_random_gaps();
    rand_gap = 1'b1;
    run("gap_a", VT, -1, VT, 0, NFR, 1, 0, 1'b1);
    run("gap_b", VT, -1, VT, 0, NFR, 1, 0, 1'b1);
    rand_gap = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_nominal();
    test_coincident();
    test_line_err();
    test_short_frame();
    test_reset_mid_frame();
    test_random_gaps();
    repeat (4) @(posedge clk);
    #2;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_drain: %0d pending writes got, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
